// File: rtl/output_write_sequencer_if.sv
// Write-side bus between the result-word producer, the output write sequencer
// and the 4-to-16 output write demux.
interface output_write_sequencer_if #(
    parameter int SEL_W = 4
);
    logic             word_valid;  // producer presents a result word
    logic             word_ready;  // sequencer can take a word this cycle
    logic [SEL_W-1:0] select;      // slot index for the demux
    logic             write;       // demux write strobe

    // Sequencer side.
    modport slave (
        input  word_valid,
        output word_ready,
        output select,
        output write
    );

    // Producer/demux side.
    modport master (
        output word_valid,
        input  word_ready,
        input  select,
        input  write
    );
endinterface

// File: rtl/output_write_sequencer.sv
// Output write sequencer: steps the demux slot select across one frame of
// NUM_SLOTS result words, then holds the bank full until it is drained.
// Completed frames are counted with a saturating counter.
module output_write_sequencer #(
    parameter int NUM_SLOTS = 16,  // slots per frame, 2..16
    parameter int SEL_W     = 4,   // 2**SEL_W >= NUM_SLOTS
    parameter int CNT_W     = 16   // completed-frame counter width
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic                   drain_i,
    output_write_sequencer_if.slave bus,
    output logic                   busy_o,
    output logic                   full_o,
    output logic                   frame_done_o,
    output logic [CNT_W-1:0]       frame_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_FULL
    } state_e;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] select_q, select_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic word_ready;
    logic accept;

    // Ready is a pure decode of the state register, so reset (which forces
    // IDLE asynchronously) also kills the write strobe with no glitch path.
    assign word_ready = (state_q == ST_FILL);
    assign accept     = bus.word_valid & word_ready;

    // Next-state, slot select, frame pulse and counter update.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        select_d     = select_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_FILL;
                    select_d = '0;
                end
            end

            ST_FILL: begin
                if (abort_i) begin
                    // An accept in this cycle still writes (write = accept)
                    // but neither advances the select nor counts.
                    state_d  = ST_IDLE;
                    select_d = '0;
                end else if (accept) begin
                    if (select_q == LAST_SEL) begin
                        state_d      = ST_FULL;
                        select_d     = '0;
                        frame_done_d = 1'b1;
                        if (frame_cnt_q != CNT_MAX) begin
                            frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        select_d = select_q + SEL_W'(1);
                    end
                end
            end

            ST_FULL: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (drain_i) begin
                    state_d  = start_i ? ST_FILL : ST_IDLE;
                    select_d = '0;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                select_d = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            select_q     <= '0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            select_q     <= select_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign bus.word_ready = word_ready;
    assign bus.select     = select_q;
    assign bus.write      = accept;
    assign busy_o         = (state_q == ST_FILL);
    assign full_o         = (state_q == ST_FULL);
    assign frame_done_o   = frame_done_q;
    assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_output_write_sequencer.sv
// Directed bench for output_write_sequencer. A second instance with a 2-bit
// frame counter shares all stimulus to exercise counter saturation.
`timescale 1ns/1ps
module tb_output_write_sequencer;

    logic clk;
    logic rst_n;
    logic start, abort, drain, valid;

    logic        busy_a, full_a, fd_a;
    logic [15:0] cnt_a;
    logic        busy_b, full_b, fd_b;
    logic [1:0]  cnt_b;

    int checks   = 0;
    int failures = 0;

    output_write_sequencer_if #(.SEL_W(4)) if_a ();
    output_write_sequencer_if #(.SEL_W(4)) if_b ();

    assign if_a.word_valid = valid;
    assign if_b.word_valid = valid;

    output_write_sequencer #(.NUM_SLOTS(16), .SEL_W(4), .CNT_W(16)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .drain_i      (drain),
        .bus          (if_a.slave),
        .busy_o       (busy_a),
        .full_o       (full_a),
        .frame_done_o (fd_a),
        .frame_cnt_o  (cnt_a)
    );

    output_write_sequencer #(.NUM_SLOTS(16), .SEL_W(4), .CNT_W(2)) dut_sat (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .drain_i      (drain),
        .bus          (if_b.slave),
        .busy_o       (busy_b),
        .full_o       (full_b),
        .frame_done_o (fd_b),
        .frame_cnt_o  (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        start = 0; abort = 0; drain = 0; valid = 0;
        rst_n = 0;
        #1;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic run_frame();
        start = 1; tick(); start = 0;
        valid = 1;
        repeat (16) tick();
        valid = 0;
    endtask

    task automatic test_reset();
        start = 0; abort = 0; drain = 0; valid = 1;
        rst_n = 0;
        #1;
        checks++;
        if ({if_a.select, if_a.word_ready, if_a.write, busy_a, full_a, fd_a} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs: got sel=%0d rdy=%b wr=%b busy=%b full=%b fd=%b, want all 0",
                     if_a.select, if_a.word_ready, if_a.write, busy_a, full_a, fd_a);
        end
        checks++;
        if (cnt_a !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d want 0", cnt_a);
        end
        @(negedge clk);
        rst_n = 1;
        valid = 0;
        tick();
        #1;
        checks++;
        if (busy_a !== 1'b0 || full_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b full=%b want 0 0", busy_a, full_a);
        end
    endtask

    task automatic test_full_frame();
        start = 1; tick(); start = 0;
        valid = 1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (if_a.write !== 1'b1 || if_a.select !== 4'(i) || fd_a !== 1'b0) begin
                failures++;
                $display("FAIL frame_slot%0d: got wr=%b sel=%0d fd=%b want 1 %0d 0",
                         i, if_a.write, if_a.select, fd_a, i);
            end
            tick();
        end
        #1;
        checks++;
        if (fd_a !== 1'b1 || full_a !== 1'b1 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL frame_end_flags: got fd=%b full=%b busy=%b want 1 1 0", fd_a, full_a, busy_a);
        end
        checks++;
        if (cnt_a !== 16'd1 || if_a.select !== 4'd0 || if_a.write !== 1'b0) begin
            failures++;
            $display("FAIL frame_end_state: got cnt=%0d sel=%0d wr=%b want 1 0 0",
                     cnt_a, if_a.select, if_a.write);
        end
        valid = 0;
        tick();
        #1;
        checks++;
        if (fd_a !== 1'b0 || full_a !== 1'b1) begin
            failures++;
            $display("FAIL frame_done_single: got fd=%b full=%b want 0 1", fd_a, full_a);
        end
    endtask

    task automatic test_alt_valid();
        logic [3:0] exp_sel;
        logic       exp_fd;
        int         writes;
        // Drain with start low returns to IDLE.
        drain = 1; tick(); drain = 0;
        #1;
        checks++;
        if (full_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL drain_to_idle: got full=%b busy=%b want 0 0", full_a, busy_a);
        end
        start = 1; tick(); start = 0;
        exp_sel = 4'd0;
        exp_fd  = 1'b0;
        writes  = 0;
        for (int c = 0; c < 32; c++) begin
            valid = (c % 2 == 0);
            #1;
            checks++;
            if (if_a.select !== exp_sel || if_a.write !== valid || fd_a !== exp_fd) begin
                failures++;
                $display("FAIL alt_cycle%0d: got sel=%0d wr=%b fd=%b want %0d %b %b",
                         c, if_a.select, if_a.write, fd_a, exp_sel, valid, exp_fd);
            end
            if (if_a.write === 1'b1) writes++;
            exp_fd = 1'b0;
            if (valid) begin
                if (exp_sel == 4'd15) begin
                    exp_sel = 4'd0;
                    exp_fd  = 1'b1;
                end else begin
                    exp_sel = exp_sel + 4'd1;
                end
            end
            tick();
        end
        valid = 0;
        #1;
        checks++;
        if (writes != 16 || full_a !== 1'b1 || cnt_a !== 16'd2) begin
            failures++;
            $display("FAIL alt_summary: got writes=%0d full=%b cnt=%0d want 16 1 2", writes, full_a, cnt_a);
        end
    endtask

    task automatic test_backpressure();
        valid = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (if_a.word_ready !== 1'b0 || if_a.write !== 1'b0 || full_a !== 1'b1) begin
                failures++;
                $display("FAIL bp_cycle%0d: got rdy=%b wr=%b full=%b want 0 0 1",
                         i, if_a.word_ready, if_a.write, full_a);
            end
            tick();
        end
        valid = 0; drain = 1; start = 1;
        tick();
        drain = 0; start = 0;
        #1;
        checks++;
        if (busy_a !== 1'b1 || if_a.select !== 4'd0) begin
            failures++;
            $display("FAIL drain_restart: got busy=%b sel=%0d want 1 0", busy_a, if_a.select);
        end
        valid = 1;
        #1;
        checks++;
        if (if_a.write !== 1'b1 || if_a.select !== 4'd0) begin
            failures++;
            $display("FAIL restart_slot0: got wr=%b sel=%0d want 1 0", if_a.write, if_a.select);
        end
        tick();
        #1;
        checks++;
        if (if_a.select !== 4'd1) begin
            failures++;
            $display("FAIL restart_slot1: got sel=%0d want 1", if_a.select);
        end
    endtask

    task automatic test_abort();
        // Continues from slot 1 with valid held high.
        repeat (6) tick();
        #1;
        checks++;
        if (if_a.select !== 4'd7) begin
            failures++;
            $display("FAIL abort_pre_sel: got %0d want 7", if_a.select);
        end
        abort = 1;
        #1;
        checks++;
        if (if_a.write !== 1'b1) begin
            failures++;
            $display("FAIL abort_write: got wr=%b want 1", if_a.write);
        end
        tick();
        abort = 0; valid = 0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || full_a !== 1'b0 || if_a.select !== 4'd0 || cnt_a !== 16'd2 || fd_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_after: got busy=%b full=%b sel=%0d cnt=%0d fd=%b want 0 0 0 2 0",
                     busy_a, full_a, if_a.select, cnt_a, fd_a);
        end
        tick();
        #1;
        checks++;
        if (fd_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_settled: got fd=%b busy=%b want 0 0", fd_a, busy_a);
        end
    endtask

    task automatic test_async_reset();
        start = 1; tick(); start = 0;
        valid = 1;
        repeat (9) tick();
        #1;
        checks++;
        if (if_a.select !== 4'd9 || if_a.write !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: got sel=%0d wr=%b want 9 1", if_a.select, if_a.write);
        end
        #1;
        rst_n = 0;
        #1;
        checks++;
        if ({if_a.select, if_a.word_ready, if_a.write, busy_a, full_a, fd_a} !== 9'b0 || cnt_a !== 16'd0) begin
            failures++;
            $display("FAIL async_reset: got sel=%0d rdy=%b wr=%b busy=%b full=%b fd=%b cnt=%0d want all 0",
                     if_a.select, if_a.word_ready, if_a.write, busy_a, full_a, fd_a, cnt_a);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        valid = 0;
        tick();
        #1;
        checks++;
        if (busy_a !== 1'b0 || full_a !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got busy=%b full=%b want 0 0", busy_a, full_a);
        end
        start = 1; tick(); start = 0;
        valid = 1;
        #1;
        checks++;
        if (busy_a !== 1'b1 || if_a.select !== 4'd0 || if_a.write !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_start: got busy=%b sel=%0d wr=%b want 1 0 1",
                     busy_a, if_a.select, if_a.write);
        end
        valid = 0;
    endtask

    task automatic test_full_abort();
        do_reset();
        run_frame();
        #1;
        checks++;
        if (full_a !== 1'b1 || cnt_a !== 16'd1) begin
            failures++;
            $display("FAIL full_abort_pre: got full=%b cnt=%0d want 1 1", full_a, cnt_a);
        end
        abort = 1; tick(); abort = 0;
        #1;
        checks++;
        if (full_a !== 1'b0 || busy_a !== 1'b0 || cnt_a !== 16'd1) begin
            failures++;
            $display("FAIL full_abort: got full=%b busy=%b cnt=%0d want 0 0 1", full_a, busy_a, cnt_a);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            run_frame();
            #1;
            checks++;
            if (cnt_a !== 16'(k) || cnt_b !== 2'((k > 3) ? 3 : k)) begin
                failures++;
                $display("FAIL sat_frame%0d: got cnt16=%0d cnt2=%0d want %0d %0d",
                         k, cnt_a, cnt_b, k, (k > 3) ? 3 : k);
            end
            drain = 1; tick(); drain = 0;
        end
    endtask

    initial begin
        start = 0; abort = 0; drain = 0; valid = 0; rst_n = 0;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_alt_valid();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_full_abort();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_write_sequencer.md
Name: output_write_sequencer

Overview:
- Sequences the 16 write strobes of the output register bank: accepts a stream of result words from a hash core over a valid/ready handshake and steps the slot select 0..15, one write per accepted word.
- Drives the select and write inputs of the existing 4-to-16 output write demux.
- Tracks the bank as a frame: fill, hold full until the consumer drains it, then rearm.
- Also counts completed frames for status readout.

Parameters:
- NUM_SLOTS, 16, number of output slots per frame; legal range 2..16.
- SEL_W, 4, select width; must satisfy 2^SEL_W >= NUM_SLOTS.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk_i  in  1  system clock, all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  arm the sequencer for a new frame (level, sampled in IDLE/FULL).
- abort_i  in  1  abandon current frame.
- word_valid_i  in  1  hash core presents a result word.
- word_ready_o  out  1  sequencer can accept a word this cycle.
- select_o  out  SEL_W  slot index for the demux (registered).
- write_o  out  1  write strobe to the demux.
- drain_i  in  1  consumer has read the full bank (single-cycle pulse).
- busy_o  out  1  high in FILL.
- full_o  out  1  high in FULL.
- frame_done_o  out  1  one-cycle pulse when the last slot is written.
- frame_cnt_o  out  CNT_W  completed frames, saturating.

Behaviour:
- Reset (async assert, sync deassert by the top level): state=IDLE, select_o=0, word_ready_o=0, write_o=0, busy_o=0, full_o=0, frame_done_o=0, frame_cnt_o=0.
- States: IDLE, FILL, FULL.
- IDLE: start_i=1 -> FILL next cycle, select_o=0.
- FILL:
  - word_ready_o=1.
  - Accept = word_valid_i & word_ready_o.
  - write_o = Accept, combinational, same cycle as the data, so the demux writes the slot addressed by the current select_o.
  - On Accept with select_o < NUM_SLOTS-1: select_o increments next cycle.
  - On Accept with select_o = NUM_SLOTS-1: next cycle state=FULL, select_o wraps to 0, frame_done_o=1 for exactly that cycle, frame_cnt_o increments.
  - No Accept: select_o holds, write_o=0.
- FULL:
  - word_ready_o=0, write_o=0, so a word_valid_i is back-pressured.
  - drain_i=1 with start_i=1: -> FILL directly.
  - drain_i=1 with start_i=0: -> IDLE.
  - drain_i=0: stay FULL regardless of start_i.
- abort_i:
  - Highest priority in FILL: next state IDLE, select_o=0.
  - Any Accept in the same cycle still produces write_o=1, but does not advance select_o and does not count.
  - Ignored in IDLE.
  - In FULL, abort_i forces IDLE; the bank contents are discarded by the consumer.
- frame_cnt_o saturates at 2^CNT_W-1 and does not wrap.
- drain_i outside FULL is ignored. start_i in FILL is ignored.
- Reset asserted mid-frame returns to the reset values immediately; no write_o glitch may escape after rst_n_i falls, since write_o is gated by the reset state.
- Throughput: one word per cycle. A frame of NUM_SLOTS words fills in NUM_SLOTS consecutive cycles when word_valid_i is held high.
- select_o never exceeds NUM_SLOTS-1.

Test Plan:
- Reset then start_i=1 for 1 cycle, word_valid_i held high 16 cycles -> write_o high 16 cycles, select_o 0,1,...,15, frame_done_o pulses once the cycle after slot 15, full_o=1, frame_cnt_o=1, select_o=0.
- In FILL, toggle word_valid_i every other cycle -> select_o advances only on cycles with valid; 32 cycles complete the frame; exactly 16 write_o pulses.
- In FULL, hold word_valid_i=1 for 10 cycles -> word_ready_o=0 and write_o=0 throughout; then drain_i pulse with start_i=1 -> FILL next cycle, select_o=0, next word written to slot 0.
- abort_i at select_o=7 with word_valid_i=1 -> write_o=1 that cycle, next cycle IDLE, select_o=0, frame_cnt_o unchanged, frame_done_o never pulses.
- rst_n_i low at select_o=9 mid-frame -> all outputs 0 asynchronously; after release, state IDLE; start_i restarts at slot 0.
- CNT_W=2, run 5 full frames -> frame_cnt_o reads 1,2,3,3,3 (saturates).
